// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings and issue-buffer state type.
// Used by alu_ctrl_issue, the ALU bench and the main decoder.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_ILL = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational map from decoded instruction fields to the 3-bit ALUControl code.
// ALU_CTRL_ILLEGAL_EN: unsupported ops map to ALU_ILL and raise the illegal flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_ctrl
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic       illegal
`endif
);

`ifdef ALU_CTRL_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic [2:0] code_raw;
  logic       unsup;

  // code_raw already carries the fallback codes used when illegal reporting is off
  always_comb begin
    code_raw = ALU_ADD;
    unsup    = 1'b0;
    unique case (aluop)
      ALUOP_MEM: code_raw = ALU_ADD;
      ALUOP_BR:  code_raw = ALU_SUB;
      ALUOP_FN: begin
        unique case (funct3)
          3'b000: code_raw = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: code_raw = ALU_SLL;
          3'b100: code_raw = ALU_XOR;
          3'b101: begin
            code_raw = ALU_SRL;
            unsup    = funct7b5;
          end
          3'b110: code_raw = ALU_OR;
          3'b111: code_raw = ALU_AND;
          default: begin
            code_raw = ALU_ADD;
            unsup    = 1'b1;
          end
        endcase
      end
      default: begin
        code_raw = ALU_ADD;
        unsup    = 1'b1;
      end
    endcase
  end

  assign alu_ctrl = (ILL_EN && unsup) ? ALU_ILL : code_raw;
`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal = unsup;
`endif

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issue stage: valid/ready input, decode, 2-entry (output + skid) buffer.
// ALU_CTRL_ILLEGAL_EN adds the out_illegal port.
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7b5,
  input  logic             in_op5,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       ALUControl,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_CTRL_ILLEGAL_EN
  ,
  output logic             out_illegal
`endif
);

  buf_state_e       state_q, state_d;
  logic [2:0]       out_code_q, out_code_d, skid_code_q, skid_code_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
  logic [2:0]       dec_code;
  logic             in_fire, out_fire, load_out, load_skid, skid_to_out;

`ifdef ALU_CTRL_ILLEGAL_EN
  logic dec_ill, out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;
`endif

  alu_ctrl_decode u_dec (
    .aluop    (in_aluop),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .op5      (in_op5),
    .alu_ctrl (dec_code)
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    .illegal  (dec_ill)
`endif
  );

  // Both handshake outputs come straight from state so neither depends on the other side
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state_q)
      ST_EMPTY: if (in_fire) begin
        load_out = 1'b1;
        state_d  = ST_ONE;
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_out = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (out_fire) begin
        skid_to_out = 1'b1;
        state_d     = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_code_d  = out_code_q;
    out_tag_d   = out_tag_q;
    skid_code_d = skid_code_q;
    skid_tag_d  = skid_tag_q;
    if (load_out) begin
      out_code_d = dec_code;
      out_tag_d  = in_tag;
    end else if (skid_to_out) begin
      out_code_d = skid_code_q;
      out_tag_d  = skid_tag_q;
    end
    if (load_skid) begin
      skid_code_d = dec_code;
      skid_tag_d  = in_tag;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  always_comb begin
    out_ill_d  = out_ill_q;
    skid_ill_d = skid_ill_q;
    if (load_out)         out_ill_d = dec_ill;
    else if (skid_to_out) out_ill_d = skid_ill_q;
    if (load_skid)        skid_ill_d = dec_ill;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ill_q  <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      out_ill_q  <= out_ill_d;
      skid_ill_q <= skid_ill_d;
    end
  end

  assign out_illegal = out_ill_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      out_code_q  <= ALU_ADD;
      out_tag_q   <= '0;
      skid_code_q <= ALU_ADD;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_code_q  <= out_code_d;
      out_tag_q   <= out_tag_d;
      skid_code_q <= skid_code_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

  assign ALUControl = out_code_q;
  assign out_tag    = out_tag_q;

endmodule
